// File: rtl/divider_seq_pkg.sv
// ---------------------------------------------------------------------------
// divider_seq_pkg
// Shared definitions for the sequential restoring divider core.
//   state_t    : controller states, IDLE=0, CALC=1, DONE=2
//   cnt_width(): width of the iteration counter, clog2(DATASIZE+1), so the
//                counter can hold the value DATASIZE itself
// ---------------------------------------------------------------------------
package divider_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEFAULT_DATASIZE = 8;

  function automatic int cnt_width(input int datasize);
    return $clog2(datasize + 1);
  endfunction

  localparam int DEFAULT_CNT_WIDTH = cnt_width(DEFAULT_DATASIZE);

endpackage

// File: rtl/divider_seq_sub.sv
// ---------------------------------------------------------------------------
// divider_seq_sub
// Combinational subtractor: diff = a - b - bin, with borrow-out.
//   WIDTH  : operand width
//   RIPPLE : 1 = explicit ripple-borrow chain, 0 = behavioural subtract
// Ports
//   a, b   : WIDTH-bit minuend / subtrahend
//   bin    : borrow-in
//   diff   : WIDTH-bit difference
//   bout   : borrow-out of the top bit (1 when a < b + bin)
// ---------------------------------------------------------------------------
module divider_seq_sub #(
  parameter int WIDTH  = 9,
  parameter bit RIPPLE = 1'b1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  generate
    if (RIPPLE) begin : g_ripple
      logic [WIDTH:0] br;

      // One full-subtractor cell per bit; the borrow ripples from bit 0 up.
      always_comb begin
        br[0] = bin;
        for (int i = 0; i < WIDTH; i++) begin
          diff[i]  = a[i] ^ b[i] ^ br[i];
          br[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
        end
      end

      assign bout = br[WIDTH];
    end else begin : g_behav
      // Widening by one bit makes the top result bit the borrow-out.
      assign {bout, diff} = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin};
    end
  endgenerate

endmodule

// File: rtl/divider_seq.sv
// ---------------------------------------------------------------------------
// divider_seq
// Sequential unsigned restoring divider, one quotient bit per clock.
// Parameters
//   DATASIZE : operand / quotient / remainder width (>= 2)
// Ports
//   iCLK   : clock, rising edge
//   iRST   : synchronous active-high reset
//   iSTART : start request, honoured only in IDLE or DONE
//   iDVD   : dividend, captured on an accepted start
//   iDVS   : divisor, captured on an accepted start
//   oQ     : quotient, updated on entry to DONE
//   oR     : remainder, updated on entry to DONE
//   oBUSY  : high while iterating (CALC)
//   oDONE  : one-cycle completion pulse (DONE)
//   oDZ    : divide-by-zero flag of the last operation
// ---------------------------------------------------------------------------
module divider_seq
  import divider_seq_pkg::*;
#(
  parameter int DATASIZE = DEFAULT_DATASIZE
) (
  input  logic                iCLK,
  input  logic                iRST,
  input  logic                iSTART,
  input  logic [DATASIZE-1:0] iDVD,
  input  logic [DATASIZE-1:0] iDVS,
  output logic [DATASIZE-1:0] oQ,
  output logic [DATASIZE-1:0] oR,
  output logic                oBUSY,
  output logic                oDONE,
  output logic                oDZ
);

  localparam int CW = cnt_width(DATASIZE);

  state_t              state;
  state_t              state_next;
  logic [DATASIZE-1:0] dvs_reg;
  logic [DATASIZE-1:0] quo_reg;
  logic [DATASIZE-1:0] rem_reg;
  logic [CW-1:0]       count;
  logic [DATASIZE:0]   shifted;
  logic [DATASIZE:0]   divisor_ext;
  logic [DATASIZE:0]   diff;
  logic                borrow;
  logic                start_ok;
  logic                last_iter;
  logic [DATASIZE-1:0] quo_next;
  logic [DATASIZE-1:0] rem_next;
  logic                unused_diff_msb;

  assign start_ok  = iSTART && ((state == ST_IDLE) || (state == ST_DONE));
  assign last_iter = (state == ST_CALC) && (count == CW'(1));

  // The dividend shifts out of quo_reg MSB-first into the partial remainder
  // while quotient bits shift in at the bottom of the same register.
  assign shifted     = {rem_reg, quo_reg[DATASIZE-1]};
  assign divisor_ext = {1'b0, dvs_reg};

  divider_seq_sub #(
    .WIDTH  (DATASIZE + 1),
    .RIPPLE (1'b1)
  ) u_sub (
    .a    (shifted),
    .b    (divisor_ext),
    .bin  (1'b0),
    .diff (diff),
    .bout (borrow)
  );

  // When the difference is kept the partial remainder is below the divisor,
  // so its top bit is always zero and only the low bits are stored.
  assign unused_diff_msb = diff[DATASIZE];

  assign quo_next = {quo_reg[DATASIZE-2:0], ~borrow};
  assign rem_next = borrow ? shifted[DATASIZE-1:0] : diff[DATASIZE-1:0];

  // State register.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and status outputs; a zero divisor bypasses CALC entirely.
  always_comb begin
    state_next = state;
    oBUSY      = 1'b0;
    oDONE      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (iSTART) begin
          state_next = (iDVS == '0) ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        oBUSY = 1'b1;
        if (count == CW'(1)) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        oDONE = 1'b1;
        if (iSTART) begin
          state_next = (iDVS == '0) ? ST_DONE : ST_CALC;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Operand capture, iteration datapath and result registers. Results are
  // written only on the last iteration (or at start for a zero divisor) so
  // they hold steady between completions.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      dvs_reg <= '0;
      quo_reg <= '0;
      rem_reg <= '0;
      count   <= '0;
      oQ      <= '0;
      oR      <= '0;
      oDZ     <= 1'b0;
    end else if (start_ok) begin
      dvs_reg <= iDVS;
      quo_reg <= iDVD;
      rem_reg <= '0;
      count   <= CW'(DATASIZE);
      oDZ     <= (iDVS == '0);
      if (iDVS == '0) begin
        oQ <= '1;
        oR <= iDVD;
      end
    end else if (state == ST_CALC) begin
      quo_reg <= quo_next;
      rem_reg <= rem_next;
      count   <= count - CW'(1);
      if (last_iter) begin
        oQ <= quo_next;
        oR <= rem_next;
      end
    end
  end

endmodule

// File: tb/tb_divider_seq.sv
// ---------------------------------------------------------------------------
// tb_divider_seq
// Directed, self-checking bench for divider_seq (DATASIZE=8). Expected
// results are pushed to a scoreboard queue when an operation is started and
// popped when oDONE is seen. Edge index k counts rising edges after the
// start-accepting edge (k=0 is that edge); outputs are sampled on falling
// edges, and inputs are driven there too.
// ---------------------------------------------------------------------------
module tb_divider_seq;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
  } exp_t;

  logic       iCLK;
  logic       iRST;
  logic       iSTART;
  logic [7:0] iDVD;
  logic [7:0] iDVS;
  logic [7:0] oQ;
  logic [7:0] oR;
  logic       oBUSY;
  logic       oDONE;
  logic       oDZ;

  exp_t sb[$];
  int   checkCount = 0;
  int   passCount  = 0;

  divider_seq #(.DATASIZE(8)) dut (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .iSTART (iSTART),
    .iDVD   (iDVD),
    .iDVS   (iDVS),
    .oQ     (oQ),
    .oR     (oR),
    .oBUSY  (oBUSY),
    .oDONE  (oDONE),
    .oDZ    (oDZ)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    iCLK = 1'b0;
    forever #5 iCLK = ~iCLK;
  end

  // Hard stop in case something upstream never returns.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic exp_t model(input logic [7:0] dvd, input logic [7:0] dvs);
    exp_t e;
    if (dvs == 8'd0) begin
      e.q  = 8'hFF;
      e.r  = dvd;
      e.dz = 1'b1;
    end else begin
      e.q  = dvd / dvs;
      e.r  = dvd % dvs;
      e.dz = 1'b0;
    end
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checkCount++;
    assert (obs === expv) passCount++;
    else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
  endtask

  // Called at a falling edge: drives the operands with iSTART, records the
  // expected result, and returns at the falling edge after the start edge.
  task automatic applyStimulus(input logic [7:0] dvd, input logic [7:0] dvs, input bit record);
    iDVD   = dvd;
    iDVS   = dvs;
    iSTART = 1'b1;
    if (record) sb.push_back(model(dvd, dvs));
    @(negedge iCLK);
    iSTART = 1'b0;
  endtask

  // Waits for oDONE from sample k=0, optionally pulsing iSTART at sample
  // pulseAt, then checks latency, busy cycle count and the scoreboard entry.
  task automatic waitDone(input string tag, input int expLat, input int pulseAt,
                          input logic [7:0] pDvd, input logic [7:0] pDvs);
    int   k;
    int   busyCnt;
    bit   seen;
    exp_t e;
    k       = 0;
    busyCnt = 0;
    seen    = 1'b0;
    while (!seen && k <= 20) begin
      if (k == pulseAt) begin
        iSTART = 1'b1;
        iDVD   = pDvd;
        iDVS   = pDvs;
      end else if (pulseAt >= 0 && k == pulseAt + 1) begin
        iSTART = 1'b0;
      end
      if (oDONE === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (k > 0 && oBUSY === 1'b1) busyCnt++;
        @(negedge iCLK);
        k++;
      end
    end
    iSTART = 1'b0;
    checkOutput({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (!seen) begin
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    checkOutput({tag, "_latency"}, k, expLat);
    checkOutput({tag, "_busy_cycles"}, busyCnt, (expLat > 0) ? expLat - 1 : 0);
    checkOutput({tag, "_busy_at_done"}, 32'(oBUSY), 32'd0);
    checkOutput({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput({tag, "_q"}, 32'(oQ), 32'(e.q));
      checkOutput({tag, "_r"}, 32'(oR), 32'(e.r));
      checkOutput({tag, "_dz"}, 32'(oDZ), 32'(e.dz));
    end
  endtask

  initial begin
    int doneSeen;
    iRST   = 1'b1;
    iSTART = 1'b0;
    iDVD   = 8'd0;
    iDVS   = 8'd0;
    repeat (2) @(negedge iCLK);
    checkOutput("rst_q", 32'(oQ), 32'd0);
    checkOutput("rst_r", 32'(oR), 32'd0);
    checkOutput("rst_busy", 32'(oBUSY), 32'd0);
    checkOutput("rst_done", 32'(oDONE), 32'd0);
    checkOutput("rst_dz", 32'(oDZ), 32'd0);
    iRST = 1'b0;
    @(negedge iCLK);

    // 100/7: eight edges to completion, busy on the seven in between.
    applyStimulus(8'd100, 8'd7, 1'b1);
    checkOutput("calc_busy_k0", 32'(oBUSY), 32'd1);
    waitDone("d100_7", 8, -1, 8'd0, 8'd0);
    @(negedge iCLK);
    checkOutput("d100_7_pulse_end", 32'(oDONE), 32'd0);
    repeat (3) @(negedge iCLK);
    checkOutput("d100_7_hold_q", 32'(oQ), 32'd14);
    checkOutput("d100_7_hold_r", 32'(oR), 32'd2);

    // Boundary operands.
    applyStimulus(8'd255, 8'd1, 1'b1);
    waitDone("d255_1", 8, -1, 8'd0, 8'd0);
    @(negedge iCLK);
    applyStimulus(8'd5, 8'd9, 1'b1);
    waitDone("d5_9", 8, -1, 8'd0, 8'd0);
    @(negedge iCLK);
    applyStimulus(8'd255, 8'd255, 1'b1);
    waitDone("d255_255", 8, -1, 8'd0, 8'd0);
    @(negedge iCLK);

    // Divide by zero completes on the start edge itself and never goes busy.
    applyStimulus(8'd42, 8'd0, 1'b1);
    waitDone("dz42", 0, -1, 8'd0, 8'd0);
    repeat (2) @(negedge iCLK);
    checkOutput("dz42_flag_hold", 32'(oDZ), 32'd1);
    checkOutput("dz42_no_busy", 32'(oBUSY), 32'd0);

    // Start request mid-CALC is ignored; a start in DONE chains immediately.
    applyStimulus(8'd200, 8'd3, 1'b1);
    checkOutput("d200_3_dz_cleared", 32'(oDZ), 32'd0);
    waitDone("d200_3", 8, 3, 8'd9, 8'd2);
    applyStimulus(8'd9, 8'd2, 1'b1);
    checkOutput("b2b_busy_k0", 32'(oBUSY), 32'd1);
    waitDone("d9_2_b2b", 8, -1, 8'd0, 8'd0);
    @(negedge iCLK);

    // Reset during the fourth CALC cycle abandons the operation.
    applyStimulus(8'd100, 8'd7, 1'b1);
    repeat (3) @(negedge iCLK);
    iRST = 1'b1;
    @(negedge iCLK);
    iRST = 1'b0;
    checkOutput("midrst_q", 32'(oQ), 32'd0);
    checkOutput("midrst_r", 32'(oR), 32'd0);
    checkOutput("midrst_busy", 32'(oBUSY), 32'd0);
    checkOutput("midrst_done", 32'(oDONE), 32'd0);
    checkOutput("midrst_dz", 32'(oDZ), 32'd0);
    void'(sb.pop_back());
    doneSeen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge iCLK);
      if (oDONE === 1'b1 || oBUSY === 1'b1) doneSeen++;
    end
    checkOutput("midrst_stays_idle", doneSeen, 0);

    // Reset wins over a simultaneous start.
    iRST   = 1'b1;
    iSTART = 1'b1;
    iDVD   = 8'd100;
    iDVS   = 8'd7;
    @(negedge iCLK);
    iRST   = 1'b0;
    iSTART = 1'b0;
    checkOutput("rst_prio_busy", 32'(oBUSY), 32'd0);
    @(negedge iCLK);
    checkOutput("rst_prio_busy_after", 32'(oBUSY), 32'd0);
    checkOutput("rst_prio_done_after", 32'(oDONE), 32'd0);

    // Fresh operation after reset.
    applyStimulus(8'd100, 8'd7, 1'b1);
    waitDone("d100_7_fresh", 8, -1, 8'd0, 8'd0);
    @(negedge iCLK);

    checkOutput("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
